secuenciador_morse: RTL

Character-level Morse sequencer for the transmitter datapath. It accepts one encoded character at a time through a valid/ready handshake and plays it out on a single keyed output. Dots, dashes and all gaps are timed in integer "units" of `UNIT_CYCLES` clock cycles. Each unit count is checked against the required duration with a 3-bit equality compare. The block sits between the character encoder (upstream) and the tone/LED driver (downstream).

---
 rtl/secuenciador_morse_pkg.sv | 24 ++
 rtl/temporizador_unidad.sv | 47 ++++
 rtl/secuenciador_morse.sv | 93 +++++++++
 3 files changed

// File: rtl/secuenciador_morse_pkg.sv
// Shared types and constants for the Morse sequencer: state enum, unit durations, length clamp.
package morse_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_GAP_SYM  = 3'd2,
    S_GAP_CHAR = 3'd3,
    S_GAP_WORD = 3'd4
  } estado_t;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;
  localparam logic [2:0] MAX_SYM        = 3'd5;

  // Lengths 6 and 7 are not meaningful symbol counts; treat them as the longest character.
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    return (len > MAX_SYM) ? MAX_SYM : len;
  endfunction

endpackage

// File: rtl/temporizador_unidad.sv
// Unit timer: tick counter (0..UNIT_CYCLES-1), 3-bit unit counter and the end-of-state compare.
module temporizador_unidad #(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [2:0] target,
  output logic       done,
  output logic       done_nxt
);

  localparam int TW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(UNIT_CYCLES - 1);

  logic [TW-1:0] tick, tick_n;
  logic [2:0]    unidad, unidad_n;

  // done_nxt looks one cycle ahead so that done is a flop that is high
  // exactly on the last cycle of the state; target belongs to that next state.
  always_comb begin
    if (clear) begin
      tick_n   = '0;
      unidad_n = 3'd0;
    end else if (tick == TICK_MAX) begin
      tick_n   = '0;
      unidad_n = unidad + 3'd1;
    end else begin
      tick_n   = tick + TW'(1);
      unidad_n = unidad;
    end
    done_nxt = (unidad_n == (target - 3'd1)) && (tick_n == TICK_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick   <= '0;
      unidad <= 3'd0;
      done   <= 1'b0;
    end else begin
      tick   <= tick_n;
      unidad <= unidad_n;
      done   <= done_nxt;
    end
  end

endmodule

// File: rtl/secuenciador_morse.sv
// Character-level Morse sequencer: valid/ready intake, FSM + pattern shift register, keyed output.
// Optional abort input enabled by defining MORSE_ABORT_EN.
module secuenciador_morse
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 6000000
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MORSE_ABORT_EN
  input  logic       abort,
`endif
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [2:0] char_len,
  input  logic [4:0] char_pat,
  output logic       tx_out,
  output logic       busy,
  output logic       sym_done,
  output logic       char_done
);

  estado_t    st, st_n;
  logic [4:0] pat, pat_n;
  logic [2:0] rem, rem_n, len_c, target;
  logic       clear, t_done, t_done_nxt;

  assign char_ready = (st == S_IDLE);

  always_comb begin
    st_n  = st;
    pat_n = pat;
    rem_n = rem;
    len_c = clamp_len(char_len);
    case (st)
      S_IDLE: if (char_valid) begin
        pat_n = char_pat;
        rem_n = len_c;
        st_n  = (len_c == 3'd0) ? S_GAP_WORD : S_MARK;
      end
      S_MARK: if (t_done) begin
        pat_n = {1'b0, pat[4:1]};
        rem_n = rem - 3'd1;
        st_n  = (rem > 3'd1) ? S_GAP_SYM : S_GAP_CHAR;
      end
      S_GAP_SYM:              if (t_done) st_n = S_MARK;
      S_GAP_CHAR, S_GAP_WORD: if (t_done) st_n = S_IDLE;
      default:                st_n = S_IDLE;
    endcase
`ifdef MORSE_ABORT_EN
    if (abort && (st != S_IDLE)) st_n = S_IDLE;
`endif
    case (st_n)
      S_MARK:     target = pat_n[0] ? DASH_UNITS : DOT_UNITS;
      S_GAP_SYM:  target = SYM_GAP_UNITS;
      S_GAP_CHAR: target = CHAR_GAP_UNITS;
      S_GAP_WORD: target = WORD_GAP_UNITS;
      default:    target = DOT_UNITS;
    endcase
    // Counters restart on every state entry and are held cleared while idle.
    clear = (st_n != st) || (st == S_IDLE);
  end

  temporizador_unidad #(.UNIT_CYCLES(UNIT_CYCLES)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .target   (target),
    .done     (t_done),
    .done_nxt (t_done_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      pat       <= 5'd0;
      rem       <= 3'd0;
      tx_out    <= 1'b0;
      busy      <= 1'b0;
      sym_done  <= 1'b0;
      char_done <= 1'b0;
    end else begin
      st        <= st_n;
      pat       <= pat_n;
      rem       <= rem_n;
      tx_out    <= (st_n == S_MARK);
      busy      <= (st_n != S_IDLE);
      sym_done  <= (st_n == S_MARK) && t_done_nxt;
      char_done <= ((st_n == S_GAP_CHAR) || (st_n == S_GAP_WORD)) && t_done_nxt;
    end
  end

endmodule
